instr_ram_banked_wrap: RTL and testbench
========================================

# instr_ram_banked_wrap

Parametrised single-port instruction-memory wrapper: successor to the fixed 32-bit single-bank wrapper. It adds:
- word-interleaved banking, with only the addressed bank enabled per access;
- a request/valid handshake with configurable read latency (optional output register);
- functional bypass (write suppression and data echo);
- a one-entry fetch buffer that serves repeated fetches of the same word without enabling a bank.

It sits between the core instruction port (plus debug/boot loader writes) and the RAM macros.

## Interface
Parameters:
- RAM_SIZE, 32768: bytes; must be a power of two.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- ADDR_WIDTH, $clog2(RAM_SIZE): byte address width.
- NUM_BANKS, 4: power of two, 1..16; interleaved on word address.
- OUT_REG, 0: 1 adds one output register stage.
- BUF_EN, 1: 0 removes the fetch buffer; every read then goes to a bank.

Ports:
- clk  in  1  clock; one clock domain.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  access request.
- gnt_o  out  1  grant; equals req_i.
- addr_i  in  ADDR_WIDTH  byte address; the low $clog2(DATA_WIDTH/8) bits are ignored.
- wdata_i  in  DATA_WIDTH  write data.
- we_i  in  1  1 = write.
- be_i  in  DATA_WIDTH/8  byte enables for writes.
- bypass_en_i  in  1  bypass mode.
- rvalid_o  out  1  response valid.
- rdata_o  out  DATA_WIDTH  response data.
- buf_hit_o  out  1  pulses with rvalid_o when the response came from the fetch buffer.

## Operation
- Addressing:
  - word address W = addr_i >> log2(DATA_WIDTH/8);
  - bank = W mod NUM_BANKS;
  - row = W / NUM_BANKS.
- Access types:
  - Accepted access = req_i & gnt_o; one per cycle, no stalls.
  - Normal write (we_i=1, bypass_en_i=0): write the bank with be_i. No response.
  - Bypass write (we_i=1, bypass_en_i=1): no bank write. A response returns wdata_i at normal read latency, buf_hit_o=0.
  - Read (we_i=0), bypass_en_i ignored: a response returns the stored word.
- Fetch buffer (BUF_EN=1), holding {valid, W, data}:
  - Read hit (valid & W match): no bank enabled; buffer data returned; buf_hit_o=1.
  - Read miss: the bank is read and the buffer loads {1, W, bank data} in the cycle the bank data returns.
  - Normal write whose W matches the buffer, or matches a miss in flight: the buffer is invalidated. The invalidate takes priority over a same-cycle load.
  - Bypass writes never touch the buffer.
- Bank enables: at most one asserted per cycle; none when the access is a hit, a bypass write, or there is no request.
- rdata_o holds its last value while rvalid_o=0.

## Timing
- Latency L = 1 + OUT_REG. An access accepted in cycle t produces rvalid_o=1 in cycle t+L. Full throughput: back-to-back reads give back-to-back rvalid_o.
- A read following a normal write to the same word in the next cycle returns the new data; the bank is write-first/read-after.
- A hit follows the same latency as a miss, so response order always equals request order.
- Hit detection uses the buffer state after any load or invalidate committed at the end of the previous cycle. Example: read A at t (miss), read A at t+1 → hit. With L=1 the load of A commits at end of t+1, after the t+1 lookup, so the t+1 read is a miss. Decided rule: lookup also compares against the in-flight miss address and counts as a hit only once the data has been loaded. Consequence: the t+1 read is a miss; the t+2 read is a hit.
- Reset values: rvalid_o=0, rdata_o=0, buf_hit_o=0, buffer valid=0, pipeline valid bits=0.
- Reset asserted mid-operation drops every in-flight response. Memory contents are undefined, not cleared.

## Structure
- Package instr_ram_pkg:
  - typedefs: word address, bank index, row index (widths from parameters via functions);
  - a localparam function returning latency L from OUT_REG.
- Sub-module instr_ram_bank: a single behavioural bank with en/we/byte-enable and 1-cycle registered read, depth RAM_SIZE/(NUM_BANKS·DATA_WIDTH/8). It is instantiated NUM_BANKS times in a generate loop; a technology macro replaces it later.
- Top-level logic:
  - bank decode;
  - response pipeline (valid, source mux select, bypass data);
  - fetch buffer and invalidate logic.

## Test plan
- Defaults; write 0xDEADBEEF to 0x100 with be=4'hF, then read 0x100 → rvalid_o one cycle later, rdata_o=0xDEADBEEF, buf_hit_o=0, only bank 0 enabled.
- Interleave: write 0x11111111, 0x22222222, 0x33333333 and 0x44444444 to 0x0, 0x4, 0x8 and 0xC, then read them back-to-back → four consecutive rvalid_o with the data in order, each from its own bank.
- Repeated fetch: read 0x200 at cycles t, t+1, t+2 → buf_hit_o=0, 0, 1; no bank enable in cycle t+2.
- Invalidate: read 0x200 (loads buffer), write be=4'b0001 data 0xAA to 0x200, read 0x200 → miss with byte 0 = 0xAA, upper bytes unchanged.
- Bypass write to 0x300 with 0xCAFEF00D → response 0xCAFEF00D; a subsequent read of 0x300 returns the old contents.
- OUT_REG=1: same scenarios with latency 2. Assert rstn_i low while two reads are in flight → no rvalid_o after release; rdata_o=0.

Source files
------------

// File: rtl/instr_ram_pkg.sv
// Shared widths, latency helper and response-source encoding for the banked
// instruction RAM wrapper.
package instr_ram_pkg;

    localparam int unsigned DEF_RAM_SIZE   = 32768;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_NUM_BANKS  = 4;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned word_addr_width(input int unsigned addr_width,
                                                    input int unsigned data_width);
        return addr_width - $clog2(data_width / 8);
    endfunction

    function automatic int unsigned row_width(input int unsigned addr_width,
                                              input int unsigned data_width,
                                              input int unsigned num_banks);
        return word_addr_width(addr_width, data_width) - $clog2(num_banks);
    endfunction

    function automatic int unsigned latency(input int unsigned out_reg);
        return 1 + ((out_reg != 0) ? 1 : 0);
    endfunction

    typedef logic [word_addr_width($clog2(DEF_RAM_SIZE), DEF_DATA_WIDTH)-1:0] word_addr_t;
    typedef logic [idx_width(DEF_NUM_BANKS)-1:0]                              bank_idx_t;
    typedef logic [row_width($clog2(DEF_RAM_SIZE), DEF_DATA_WIDTH,
                             DEF_NUM_BANKS)-1:0]                              row_idx_t;

    typedef enum logic [1:0] {
        SRC_BANK = 2'd0,
        SRC_BUF  = 2'd1,
        SRC_BYP  = 2'd2
    } rsp_src_e;

endpackage

// File: rtl/instr_ram_banked_wrap_bank.sv
// Behavioural single-port RAM bank: byte-enabled write, one-cycle registered
// read. Stands in for a technology macro.
module instr_ram_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents and read register are not reset, like the macro it models.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < int'(BE_W); i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/instr_ram_banked_wrap.sv
// Word-interleaved banked instruction RAM wrapper with fixed-latency response
// pipeline, functional bypass and a one-entry fetch buffer.
module instr_ram_banked_wrap
    import instr_ram_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned BUF_EN     = 1
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic                    bypass_en_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    buf_hit_o
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned WA_W  = word_addr_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned BK_W  = idx_width(NUM_BANKS);
    localparam int unsigned BK_SH = $clog2(NUM_BANKS);
    localparam int unsigned ROW_W = row_width(ADDR_WIDTH, DATA_WIDTH, NUM_BANKS);
    localparam int unsigned DEPTH = RAM_SIZE / (NUM_BANKS * BE_W);
    localparam int unsigned LAT   = latency(OUT_REG);

    logic [WA_W-1:0]       word;
    logic [BK_W-1:0]       bank;
    logic [ROW_W-1:0]      row;
    logic                  is_wr;
    logic                  is_byp;
    logic                  is_rd;
    logic                  hit;
    logic                  miss;
    logic [NUM_BANKS-1:0]  bank_en;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    logic                  buf_valid_q;
    logic [WA_W-1:0]       buf_word_q;
    logic [DATA_WIDTH-1:0] buf_data_q;
    logic                  buf_inval;
    logic                  buf_load;

    logic                  s1_valid;
    logic                  s1_miss;
    rsp_src_e              s1_src;
    logic [BK_W-1:0]       s1_bank;
    logic [WA_W-1:0]       s1_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_hit;

    assign gnt_o = req_i;

    // Address decode: bank from low word bits, row from the rest.
    assign word = addr_i[ADDR_WIDTH-1:OFF_W];
    assign bank = (NUM_BANKS > 1) ? word[BK_W-1:0] : '0;
    assign row  = ROW_W'(word >> BK_SH);

    if (OFF_W > 0) begin : g_off
        logic unused_addr_lsb;
        assign unused_addr_lsb = ^addr_i[OFF_W-1:0];
    end

    assign is_wr  = req_i & we_i & ~bypass_en_i;
    assign is_byp = req_i & we_i & bypass_en_i;
    assign is_rd  = req_i & ~we_i;

    // Lookup sees only committed buffer state; an in-flight miss is not a hit yet.
    assign hit  = (BUF_EN != 0) && is_rd && buf_valid_q && (buf_word_q == word);
    assign miss = is_rd & ~hit;

    always_comb begin
        bank_en = '0;
        if (is_wr || miss) begin
            bank_en[bank] = 1'b1;
        end
    end

    for (genvar g = 0; g < int'(NUM_BANKS); g++) begin : g_bank
        instr_ram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_W     (ROW_W)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[g]),
            .we    (we_i),
            .be    (be_i),
            .addr  (row),
            .wdata (wdata_i),
            .rdata (bank_rdata[g])
        );
    end

    // First response stage: remembers where the data will come from.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid <= 1'b0;
            s1_miss  <= 1'b0;
            s1_src   <= SRC_BANK;
            s1_bank  <= '0;
            s1_word  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= is_rd | is_byp;
            s1_miss  <= miss;
            if (is_rd || is_byp) begin
                s1_src  <= hit ? SRC_BUF : (is_byp ? SRC_BYP : SRC_BANK);
                s1_bank <= bank;
                s1_word <= word;
                s1_data <= is_byp ? wdata_i : buf_data_q;
            end
        end
    end

    assign rsp_data = (s1_src == SRC_BANK) ? bank_rdata[s1_bank] : s1_data;
    assign rsp_hit  = s1_valid && (s1_src == SRC_BUF);

    // A normal write to the buffered word or the word being loaded kills the entry.
    assign buf_inval = is_wr && ((buf_valid_q && (buf_word_q == word)) ||
                                 (s1_miss && (s1_word == word)));
    assign buf_load  = (BUF_EN != 0) && s1_miss;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            buf_valid_q <= 1'b0;
            buf_word_q  <= '0;
            buf_data_q  <= '0;
        end else if (buf_inval) begin
            buf_valid_q <= 1'b0;
        end else if (buf_load) begin
            buf_valid_q <= 1'b1;
            buf_word_q  <= s1_word;
            buf_data_q  <= bank_rdata[s1_bank];
        end
    end

    if (LAT > 1) begin : g_out_reg
        logic                  rvalid_q;
        logic                  buf_hit_q;
        logic [DATA_WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge rstn_i) begin
            if (!rstn_i) begin
                rvalid_q  <= 1'b0;
                buf_hit_q <= 1'b0;
                rdata_q   <= '0;
            end else begin
                rvalid_q  <= s1_valid;
                buf_hit_q <= rsp_hit;
                if (s1_valid) begin
                    rdata_q <= rsp_data;
                end
            end
        end

        assign rvalid_o  = rvalid_q;
        assign buf_hit_o = buf_hit_q;
        assign rdata_o   = rdata_q;
    end else begin : g_out_comb
        logic [DATA_WIDTH-1:0] rdata_hold_q;

        // Keeps rdata_o stable between responses.
        always_ff @(posedge clk or negedge rstn_i) begin
            if (!rstn_i) begin
                rdata_hold_q <= '0;
            end else if (s1_valid) begin
                rdata_hold_q <= rsp_data;
            end
        end

        assign rvalid_o  = s1_valid;
        assign buf_hit_o = rsp_hit;
        assign rdata_o   = s1_valid ? rsp_data : rdata_hold_q;
    end

endmodule

// File: tb/tb_instr_ram_banked_wrap.sv
// Bench for instr_ram_banked_wrap: OUT_REG=0 and OUT_REG=1 instances share stimulus.
module tb_instr_ram_banked_wrap;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 15;
    localparam int unsigned NCYC = 2048;

    logic clk = 1'b0;
    logic rstn_i = 1'b1;
    logic req_i = 1'b0;
    logic we_i = 1'b0;
    logic bypass_en_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [3:0]    be_i = '0;

    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [1:0]    buf_hit;
    logic [DW-1:0] rdata [2];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // observation log, indexed by cycle
    logic          l_rv  [2][NCYC];
    logic          l_hit [2][NCYC];
    logic [DW-1:0] l_rd  [2][NCYC];
    logic [3:0]    l_en  [2][NCYC];

    // expected response for the access issued in a cycle
    logic          e_v   [NCYC];
    logic          e_hit [NCYC];
    logic [DW-1:0] e_d   [NCYC];
    logic [3:0]    e_en  [NCYC];

    // reference model: word-addressed memory plus one-entry buffer
    logic [DW-1:0] m_mem [int unsigned];
    bit            m_bv = 0;
    int unsigned   m_bw = 0;
    logic [DW-1:0] m_bd = '0;
    bit            m_pv = 0;
    int unsigned   m_pw = 0;
    logic [DW-1:0] m_pd = '0;

    always #5 clk = ~clk;

    instr_ram_banked_wrap #(.OUT_REG(0)) u0 (
        .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .gnt_o(gnt[0]), .addr_i(addr_i),
        .wdata_i(wdata_i), .we_i(we_i), .be_i(be_i), .bypass_en_i(bypass_en_i),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .buf_hit_o(buf_hit[0])
    );

    instr_ram_banked_wrap #(.OUT_REG(1)) u1 (
        .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .gnt_o(gnt[1]), .addr_i(addr_i),
        .wdata_i(wdata_i), .we_i(we_i), .be_i(be_i), .bypass_en_i(bypass_en_i),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .buf_hit_o(buf_hit[1])
    );

    task automatic model_access(input logic r, input logic w, input logic b,
                                input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [3:0] be, input int c);
        int unsigned   wa;
        logic [DW-1:0] cur;
        bit            inval;
        bit            miss;
        wa = 32'(a) >> 2;
        inval = 0;
        miss = 0;
        e_v[c] = 1'b0; e_hit[c] = 1'b0; e_d[c] = '0; e_en[c] = '0;
        if (r && w && b) begin
            e_v[c] = 1'b1;
            e_d[c] = d;
        end else if (r && w) begin
            cur = m_mem.exists(wa) ? m_mem[wa] : '0;
            for (int i = 0; i < 4; i++) if (be[i]) cur[i*8 +: 8] = d[i*8 +: 8];
            m_mem[wa] = cur;
            inval = (m_bv && m_bw == wa) || (m_pv && m_pw == wa);
            e_en[c] = 4'(1 << (wa % 4));
        end else if (r) begin
            e_v[c] = 1'b1;
            if (m_bv && m_bw == wa) begin
                e_d[c] = m_bd;
                e_hit[c] = 1'b1;
            end else begin
                miss = 1;
                e_d[c] = m_mem.exists(wa) ? m_mem[wa] : '0;
                e_en[c] = 4'(1 << (wa % 4));
            end
        end
        if (inval) m_bv = 0;
        else if (m_pv) begin m_bv = 1; m_bw = m_pw; m_bd = m_pd; end
        m_pv = miss; m_pw = wa; m_pd = e_d[c];
    endtask

    // One clock: log outputs of this cycle, apply inputs, advance.
    task automatic step(input logic r, input logic w, input logic b,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] e);
        for (int k = 0; k < 2; k++) begin
            l_rv[k][cyc] = rvalid[k];
            l_hit[k][cyc] = buf_hit[k];
            l_rd[k][cyc] = rdata[k];
        end
        req_i = r; we_i = w; bypass_en_i = b; addr_i = a; wdata_i = d; be_i = e;
        #1;
        l_en[0][cyc] = u0.bank_en;
        l_en[1][cyc] = u1.bank_en;
        model_access(r, w, b, a, d, e, cyc);
        @(posedge clk);
        #1;
        if (cyc >= int'(NCYC) - 1) begin
            $display("FAIL log_overflow cyc=%0d limit=%0d", cyc, NCYC);
            n_err++;
            $fatal(1, "log overflow");
        end
        cyc++;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] e);
        step(1'b1, 1'b1, 1'b0, a, d, e);
    endtask
    task automatic rd(input logic [AW-1:0] a);
        step(1'b1, 1'b0, 1'b0, a, '0, 4'h0);
    endtask
    task automatic byp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b1, 1'b1, 1'b1, a, d, 4'hF);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic test_reset();
        #2 rstn_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (rvalid[k] !== 1'b0) begin $display("FAIL reset_rvalid dut%0d got=%b exp=0", k, rvalid[k]); n_err++; end
            n_chk++;
            if (rdata[k] !== '0) begin $display("FAIL reset_rdata dut%0d got=%h exp=0", k, rdata[k]); n_err++; end
            n_chk++;
            if (buf_hit[k] !== 1'b0) begin $display("FAIL reset_hit dut%0d got=%b exp=0", k, buf_hit[k]); n_err++; end
        end
        req_i = 1'b1;
        #1;
        n_chk++;
        if (gnt !== 2'b11) begin $display("FAIL gnt_follows_req got=%b exp=11", gnt); n_err++; end
        req_i = 1'b0;
        @(posedge clk);
        #1 rstn_i = 1'b1;
        m_bv = 0; m_pv = 0;
    endtask

    task automatic test_basic();
        int c0 = cyc;
        wr(15'h100, 32'hDEADBEEF, 4'hF);
        rd(15'h100);
        idle(3);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (l_rv[k][c0+1+k] !== 1'b0) begin $display("FAIL basic_write_no_rsp dut%0d got=%b exp=0", k, l_rv[k][c0+1+k]); n_err++; end
            n_chk++;
            if (l_rv[k][c0+2+k] !== 1'b1) begin $display("FAIL basic_rvalid dut%0d got=%b exp=1", k, l_rv[k][c0+2+k]); n_err++; end
            n_chk++;
            if (l_rd[k][c0+2+k] !== 32'hDEADBEEF) begin $display("FAIL basic_rdata dut%0d got=%h exp=deadbeef", k, l_rd[k][c0+2+k]); n_err++; end
            n_chk++;
            if (l_hit[k][c0+2+k] !== 1'b0) begin $display("FAIL basic_hit dut%0d got=%b exp=0", k, l_hit[k][c0+2+k]); n_err++; end
            n_chk++;
            if (l_en[k][c0] !== 4'b0001 || l_en[k][c0+1] !== 4'b0001) begin
                $display("FAIL basic_bank_en dut%0d got=%b/%b exp=0001/0001", k, l_en[k][c0], l_en[k][c0+1]); n_err++;
            end
        end
    endtask

    task automatic test_interleave();
        int c0 = cyc;
        for (int i = 0; i < 4; i++) wr(AW'(4 * i), 32'h11111111 * 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) rd(AW'(4 * i));
        idle(3);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (l_rv[k][c0+5+i+k] !== 1'b1 || l_rd[k][c0+5+i+k] !== 32'h11111111 * 32'(i + 1)) begin
                    $display("FAIL interleave_rsp dut%0d idx%0d got=%b/%h exp=1/%h", k, i,
                             l_rv[k][c0+5+i+k], l_rd[k][c0+5+i+k], 32'h11111111 * 32'(i + 1));
                    n_err++;
                end
                n_chk++;
                if (l_en[k][c0+4+i] !== 4'(1 << i)) begin
                    $display("FAIL interleave_bank_en dut%0d idx%0d got=%b exp=%b", k, i, l_en[k][c0+4+i], 4'(1 << i));
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_repeat_fetch();
        int c0 = cyc;
        logic [3:0] exp_en;
        wr(15'h200, 32'h12345678, 4'hF);
        for (int j = 0; j < 3; j++) rd(15'h200);
        idle(3);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                n_chk++;
                if (l_rv[k][c0+2+j+k] !== 1'b1 || l_rd[k][c0+2+j+k] !== 32'h12345678 ||
                    l_hit[k][c0+2+j+k] !== (j == 2)) begin
                    $display("FAIL repeat_fetch dut%0d rd%0d got=%b/%h/hit%b exp=1/12345678/hit%b", k, j,
                             l_rv[k][c0+2+j+k], l_rd[k][c0+2+j+k], l_hit[k][c0+2+j+k], j == 2);
                    n_err++;
                end
                exp_en = (j == 2) ? 4'b0000 : 4'b0001;
                n_chk++;
                if (l_en[k][c0+1+j] !== exp_en) begin
                    $display("FAIL repeat_bank_en dut%0d rd%0d got=%b exp=%b", k, j, l_en[k][c0+1+j], exp_en);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_invalidate();
        int c0 = cyc;
        rd(15'h200);
        idle(1);
        wr(15'h200, 32'h000000AA, 4'b0001);
        rd(15'h200);
        idle(3);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (l_hit[k][c0+1+k] !== 1'b1 || l_rd[k][c0+1+k] !== 32'h12345678) begin
                $display("FAIL inval_pre_hit dut%0d got=hit%b/%h exp=hit1/12345678", k, l_hit[k][c0+1+k], l_rd[k][c0+1+k]);
                n_err++;
            end
            n_chk++;
            if (l_rv[k][c0+4+k] !== 1'b1 || l_hit[k][c0+4+k] !== 1'b0 || l_rd[k][c0+4+k] !== 32'h123456AA) begin
                $display("FAIL inval_miss dut%0d got=%b/hit%b/%h exp=1/hit0/123456aa", k,
                         l_rv[k][c0+4+k], l_hit[k][c0+4+k], l_rd[k][c0+4+k]);
                n_err++;
            end
            n_chk++;
            if (l_en[k][c0+3] !== 4'b0001) begin $display("FAIL inval_bank_en dut%0d got=%b exp=0001", k, l_en[k][c0+3]); n_err++; end
        end
    endtask

    task automatic test_bypass();
        int c0 = cyc;
        wr(15'h300, 32'h55667788, 4'hF);
        byp(15'h300, 32'hCAFEF00D);
        rd(15'h300);
        idle(3);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (l_rv[k][c0+2+k] !== 1'b1 || l_rd[k][c0+2+k] !== 32'hCAFEF00D || l_hit[k][c0+2+k] !== 1'b0) begin
                $display("FAIL bypass_echo dut%0d got=%b/%h/hit%b exp=1/cafef00d/hit0", k,
                         l_rv[k][c0+2+k], l_rd[k][c0+2+k], l_hit[k][c0+2+k]);
                n_err++;
            end
            n_chk++;
            if (l_en[k][c0+1] !== 4'b0000) begin $display("FAIL bypass_bank_en dut%0d got=%b exp=0000", k, l_en[k][c0+1]); n_err++; end
            n_chk++;
            if (l_rv[k][c0+3+k] !== 1'b1 || l_rd[k][c0+3+k] !== 32'h55667788) begin
                $display("FAIL bypass_no_write dut%0d got=%b/%h exp=1/55667788", k, l_rv[k][c0+3+k], l_rd[k][c0+3+k]);
                n_err++;
            end
        end
    endtask

    task automatic test_random();
        int c0;
        logic [AW-1:0] a;
        logic [AW-1:0] prev;
        prev = 15'h400;
        for (int i = 0; i < 16; i++) wr(AW'(15'h400 + 4 * i), $urandom, 4'hF);
        c0 = cyc;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 1) == 0) ? prev : AW'(15'h400 + 4 * $urandom_range(0, 15));
            prev = a;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 a, $urandom, 4'($urandom));
        end
        idle(3);
        for (int c = c0; c <= cyc - 3; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (l_rv[k][c+1+k] !== e_v[c]) begin
                    $display("FAIL rand_rvalid dut%0d cyc%0d got=%b exp=%b", k, c, l_rv[k][c+1+k], e_v[c]);
                    n_err++;
                end else if (e_v[c]) begin
                    n_chk++;
                    if (l_rd[k][c+1+k] !== e_d[c] || l_hit[k][c+1+k] !== e_hit[c]) begin
                        $display("FAIL rand_rsp dut%0d cyc%0d got=%h/hit%b exp=%h/hit%b", k, c,
                                 l_rd[k][c+1+k], l_hit[k][c+1+k], e_d[c], e_hit[c]);
                        n_err++;
                    end
                end
                n_chk++;
                if (l_en[k][c] !== e_en[c]) begin
                    $display("FAIL rand_bank_en dut%0d cyc%0d got=%b exp=%b", k, c, l_en[k][c], e_en[c]);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        rd(15'h100);
        rd(15'h104);
        rstn_i = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (rvalid[k] !== 1'b0 || rdata[k] !== '0) begin
                $display("FAIL rst_async dut%0d got=%b/%h exp=0/0", k, rvalid[k], rdata[k]); n_err++;
            end
        end
        req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (rvalid[k] !== 1'b0 || rdata[k] !== '0) begin
                    $display("FAIL rst_drop dut%0d cyc%0d got=%b/%h exp=0/0", k, n, rvalid[k], rdata[k]); n_err++;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_interleave();
        test_repeat_fetch();
        test_invalidate();
        test_bypass();
        test_random();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
